// File: rtl/fft_pkg.sv
// Shared sizing and types for the FFT output unpacker.
package fft_pkg;
  localparam int DW     = 16;             // signed 8.8 sample width
  localparam int LANES  = 16;             // points per FFT output beat
  localparam int NPOINT = 1024;           // points per transform, multiple of LANES
  localparam int IDXW   = $clog2(NPOINT);
  localparam int LW     = $clog2(LANES);
  localparam int NSLOT  = 2;

  typedef logic signed [DW-1:0] sample_t;
  // Packed so that lane k occupies bits [DW*k +: DW], matching the FFT bus.
  typedef sample_t [LANES-1:0] lane_vec_t;

  typedef enum logic {PH_REAL, PH_IMAG} phase_e;
endpackage

// File: rtl/fft_frame_unpacker_if.sv
// FFT-side beat bus plus the serial complex-sample stream and status.
interface fft_frame_unpacker_if;
  import fft_pkg::*;

  logic               fft_valid;
  logic [DW*LANES-1:0] fft_d;
  logic               done;
  logic               out_valid;
  logic               out_ready;
  sample_t            out_re;
  sample_t            out_im;
  logic [IDXW-1:0]    out_idx;
  logic               out_last;
  logic               complete;
  logic               err_overflow;
  logic               err_orphan;

  // master: FFT core + downstream consumer side
  modport master (
    output fft_valid, fft_d, done, out_ready,
    input  out_valid, out_re, out_im, out_idx, out_last,
           complete, err_overflow, err_orphan
  );

  // slave: the unpacker
  modport slave (
    input  fft_valid, fft_d, done, out_ready,
    output out_valid, out_re, out_im, out_idx, out_last,
           complete, err_overflow, err_orphan
  );
endinterface

// File: rtl/fft_frame_slot.sv
// One ping-pong slot: real/imag lane vectors, full flag, lane read mux.
module fft_frame_slot
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_re,    // load real beat
  input  logic          cap_im,    // load imag beat and mark slot full
  input  logic          free_slot, // last lane handed off
  input  lane_vec_t     d,
  input  logic [LW-1:0] rd_lane,
  output sample_t       rd_re,
  output sample_t       rd_im,
  output logic          full
);
  lane_vec_t re_q, im_q;

  // Real lane storage; cleared on reset so idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (!rst)        re_q <= '0;
    else if (cap_re) re_q <= d;
  end

  // Imag lane storage.
  always_ff @(posedge clk) begin
    if (!rst)        im_q <= '0;
    else if (cap_im) im_q <= d;
  end

  // Full flag: set on imag capture, cleared when the reader finishes the slot.
  // Both never target the same slot in one cycle; set is given priority anyway.
  always_ff @(posedge clk) begin
    if (!rst)           full <= 1'b0;
    else if (cap_im)    full <= 1'b1;
    else if (free_slot) full <= 1'b0;
  end

  assign rd_re = re_q[rd_lane];
  assign rd_im = im_q[rd_lane];
endmodule

// File: rtl/fft_frame_unpacker.sv
// Captures real/imag beat pairs into two ping-pong slots and replays them
// as a serial complex-sample stream with a running point index.
module fft_frame_unpacker
  import fft_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  fft_frame_unpacker_if.slave bus
);
  phase_e          phase_q, phase_d;
  logic            drop_q, drop_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic            cmpl_q, cmpl_d;
  logic            ovf_q, ovf_d;
  logic            orph_q, orph_d;

  logic [NSLOT-1:0] cap_re, cap_im, free_slot, full;
  sample_t [NSLOT-1:0] slot_re, slot_im;

  logic in_v, hs, last_lane, drain_done, done_rise, wr_free;

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    fft_frame_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .cap_re    (cap_re[s]),
      .cap_im    (cap_im[s]),
      .free_slot (free_slot[s]),
      .d         (lane_vec_t'(bus.fft_d)),
      .rd_lane   (lane_q),
      .rd_re     (slot_re[s]),
      .rd_im     (slot_im[s]),
      .full      (full[s])
    );
  end

  // State register for the input phase FSM and the output-side counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= PH_REAL;
      drop_q   <= 1'b0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      lane_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      cmpl_q   <= 1'b0;
      ovf_q    <= 1'b0;
      orph_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      drop_q   <= drop_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      cmpl_q   <= cmpl_d;
      ovf_q    <= ovf_d;
      orph_q   <= orph_d;
    end
  end

  // Next-state: beat capture / drop, done handling, output handshake.
  always_comb begin
    phase_d   = phase_q;
    drop_d    = drop_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    lane_d    = lane_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    orph_d    = orph_q;
    cap_re    = '0;
    cap_im    = '0;
    free_slot = '0;

    in_v       = bus.fft_valid && !cmpl_q;   // beats after complete are ignored
    hs         = full[rd_sel_q] && bus.out_ready;
    last_lane  = (lane_q == LW'(LANES-1));
    drain_done = hs && last_lane;
    done_rise  = bus.done && !done_q;
    // A slot being emptied by this cycle's final handshake may be refilled now.
    wr_free    = !full[wr_sel_q] || (drain_done && (rd_sel_q == wr_sel_q));

    done_d = done_q | bus.done;
    cmpl_d = cmpl_q | (done_q && (full == '0) && (phase_q == PH_REAL));

    unique case (phase_q)
      PH_REAL: begin
        if (in_v) begin
          if (wr_free) begin
            cap_re[wr_sel_q] = 1'b1;
            drop_d           = 1'b0;
          end else begin
            ovf_d  = 1'b1;
            drop_d = 1'b1;
          end
          phase_d = PH_IMAG;
        end
      end
      PH_IMAG: begin
        if (in_v) begin
          // An imag beat coincident with done completes normally.
          if (!drop_q) begin
            cap_im[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
          end
          drop_d  = 1'b0;
          phase_d = PH_REAL;
        end else if (done_rise) begin
          // Real beat without its imag partner: abandon it, slot stays empty.
          orph_d  = 1'b1;
          drop_d  = 1'b0;
          phase_d = PH_REAL;
        end
      end
      default: phase_d = PH_REAL;
    endcase

    if (hs) begin
      idx_d  = (idx_q == IDXW'(NPOINT-1)) ? '0 : idx_q + IDXW'(1);
      lane_d = last_lane ? '0 : lane_q + LW'(1);
      if (last_lane) begin
        free_slot[rd_sel_q] = 1'b1;
        rd_sel_d            = ~rd_sel_q;
      end
    end
  end

  // Output stream is a straight read of the current slot/lane; it only
  // changes on a handshake, so it holds while the consumer stalls.
  assign bus.out_valid    = full[rd_sel_q];
  assign bus.out_re       = slot_re[rd_sel_q];
  assign bus.out_im       = slot_im[rd_sel_q];
  assign bus.out_idx      = idx_q;
  assign bus.out_last     = full[rd_sel_q] && (idx_q == IDXW'(NPOINT-1));
  assign bus.complete     = cmpl_q;
  assign bus.err_overflow = ovf_q;
  assign bus.err_orphan   = orph_q;
endmodule

// File: tb/tb_fft_frame_unpacker.sv
// Directed bench for fft_frame_unpacker: inputs driven and outputs sampled
// on the falling edge; a queue of expected samples checks the stream.
module tb_fft_frame_unpacker;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_frame_unpacker_if bus();
  fft_frame_unpacker dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [DW-1:0] re; logic [DW-1:0] im;} samp_t;

  int total = 0;
  int bad   = 0;
  samp_t expq[$];
  int exp_idx, n_got, n_last;
  int rdy_mode;                  // 0 low, 1 high, 2 alternate 1,0,1,0
  logic rdy_t;
  logic stalled;
  logic [DW-1:0]   h_re, h_im;
  logic [IDXW-1:0] h_idx;
  logic            h_last;
  logic obs_valid, obs_cmpl, obs_ovf, obs_orph;
  logic [DW-1:0] obs_im;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*LANES-1:0] mk_re(input int p);
    logic [DW*LANES-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = {8'(p*LANES + k + 1), 8'(p)};
    return v;
  endfunction

  function automatic logic [DW*LANES-1:0] mk_im(input int p);
    logic [DW*LANES-1:0] v;
    logic [DW-1:0] r;
    v = mk_re(p);
    for (int k = 0; k < LANES; k++) begin
      r = v[k*DW +: DW];
      v[k*DW +: DW] = -r;
    end
    return v;
  endfunction

  // One clock: observe/consume at the falling edge, then set next inputs.
  task automatic cyc(input logic fv, input logic [DW*LANES-1:0] d, input logic dn);
    logic rdy;
    samp_t s;
    @(negedge clk);
    rdy = (rdy_mode == 1) || (rdy_mode == 2 && rdy_t);
    if (rdy_mode == 2) rdy_t = ~rdy_t;
    obs_valid = bus.out_valid;
    obs_im    = bus.out_im;
    obs_cmpl  = bus.complete;
    obs_ovf   = bus.err_overflow;
    obs_orph  = bus.err_orphan;
    if (bus.out_valid && stalled) begin
      chk("hold_re",   {16'h0, bus.out_re}, {16'h0, h_re});
      chk("hold_im",   {16'h0, bus.out_im}, {16'h0, h_im});
      chk("hold_idx",  32'(bus.out_idx), 32'(h_idx));
      chk("hold_last", 32'(bus.out_last), 32'(h_last));
    end
    if (bus.out_valid && rdy) begin
      chk("sample_expected", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        s = expq.pop_front();
        chk("out_re",   {16'h0, bus.out_re}, {16'h0, s.re});
        chk("out_im",   {16'h0, bus.out_im}, {16'h0, s.im});
        chk("out_idx",  32'(bus.out_idx), 32'(exp_idx));
        chk("out_last", 32'(bus.out_last), 32'(exp_idx == NPOINT-1));
      end
      exp_idx = (exp_idx + 1) % NPOINT;
      n_got++;
      if (bus.out_last) n_last++;
      stalled = 1'b0;
    end else if (bus.out_valid) begin
      stalled = 1'b1;
      h_re = bus.out_re; h_im = bus.out_im; h_idx = bus.out_idx; h_last = bus.out_last;
    end else begin
      stalled = 1'b0;
    end
    bus.out_ready = rdy;
    bus.fft_valid = fv;
    bus.fft_d     = d;
    bus.done      = dn;
  endtask

  task automatic send_pair(input int p, input bit accept, input logic dn);
    logic [DW*LANES-1:0] r, i;
    samp_t s;
    r = mk_re(p);
    i = mk_im(p);
    cyc(1'b1, r, 1'b0);
    cyc(1'b1, i, dn);
    if (accept)
      for (int k = 0; k < LANES; k++) begin
        s.re = r[k*DW +: DW];
        s.im = i[k*DW +: DW];
        expq.push_back(s);
      end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_left", 32'(expq.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.fft_valid = 1'b0; bus.fft_d = '0; bus.done = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    exp_idx = 0; n_got = 0; n_last = 0; stalled = 1'b0; rdy_t = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy_mode = 0;
    bus.fft_valid = 1'b0; bus.fft_d = '0; bus.done = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_re",    {16'h0, bus.out_re}, 0);
    chk("rst_idx",   32'(bus.out_idx), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    chk("rst_cmpl",  32'(bus.complete), 0);
    chk("rst_ovf",   32'(bus.err_overflow), 0);
    chk("rst_orph",  32'(bus.err_orphan), 0);

    // Single pair: lane0 real 0x0100, imag 0xFF00; valid the cycle after imag
    rdy_mode = 1;
    send_pair(0, 1, 1'b0);
    chk("lat_before", 32'(obs_valid), 0);
    cyc(1'b0, '0, 1'b0);
    chk("lat_valid", 32'(obs_valid), 1);
    chk("first_im",  32'(obs_im), 32'h0000FF00);
    drain(40);
    chk("single_cnt", n_got, 16);

    // Full transform. A 1-sample/cycle consumer drains one pair per 16
    // cycles, so pairs are paced at that rate; done rides on the last imag.
    do_reset();
    rdy_mode = 1;
    for (int p = 0; p < NPOINT/LANES; p++) begin
      send_pair(p, 1, logic'(p == NPOINT/LANES - 1));
      if (p != NPOINT/LANES - 1) repeat (LANES - 2) cyc(1'b0, '0, 1'b0);
    end
    drain(100);
    cyc(1'b0, '0, 1'b0);
    chk("full_cmpl_early", 32'(obs_cmpl), 0);
    cyc(1'b0, '0, 1'b0);
    chk("full_cmpl",  32'(obs_cmpl), 1);
    chk("full_cnt",   n_got, NPOINT);
    chk("full_lasts", n_last, 1);
    chk("full_ovf",   32'(obs_ovf), 0);
    chk("full_orph",  32'(obs_orph), 0);

    // Backpressure: ready alternates, samples must hold while stalled
    do_reset();
    rdy_mode = 2;
    send_pair(1, 1, 1'b0);
    send_pair(2, 1, 1'b0);
    drain(200);
    chk("bp_cnt", n_got, 32);

    // Overflow: ready low, third pair dropped
    do_reset();
    rdy_mode = 0;
    send_pair(3, 1, 1'b0);
    send_pair(4, 1, 1'b0);
    chk("ovf_before", 32'(obs_ovf), 0);
    cyc(1'b1, mk_re(5), 1'b0);
    cyc(1'b1, mk_im(5), 1'b0);
    chk("ovf_set", 32'(obs_ovf), 1);
    rdy_mode = 1;
    drain(100);
    chk("ovf_cnt", n_got, 32);
    chk("ovf_idx", exp_idx, 32);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_idle", 32'(obs_valid), 0);

    // Orphan: real beat then done, no imag
    do_reset();
    rdy_mode = 1;
    cyc(1'b1, mk_re(6), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("orph_set",   32'(obs_orph), 1);
    chk("orph_cmpl0", 32'(obs_cmpl), 0);
    cyc(1'b0, '0, 1'b0);
    chk("orph_cmpl",  32'(obs_cmpl), 1);
    send_pair(7, 0, 1'b0);            // ignored after complete
    repeat (4) cyc(1'b0, '0, 1'b0);
    chk("orph_valid", 32'(obs_valid), 0);
    chk("orph_cnt",   n_got, 0);

    // Reset mid-stream while idx 5 is presented
    do_reset();
    rdy_mode = 0;
    send_pair(8, 1, 1'b0);
    send_pair(9, 1, 1'b0);
    cyc(1'b1, mk_re(10), 1'b0);
    cyc(1'b1, mk_im(10), 1'b0);
    rdy_mode = 1;
    for (int n = 0; n < 20 && exp_idx != 5; n++) cyc(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("mid_idx5", 32'(bus.out_idx), 5);
    chk("mid_ovf",  32'(bus.err_overflow), 1);
    rst = 1'b0;
    bus.fft_valid = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(bus.out_valid), 0);
    chk("mid_ovf0",  32'(bus.err_overflow), 0);
    chk("mid_orph0", 32'(bus.err_orphan), 0);
    chk("mid_cmpl0", 32'(bus.complete), 0);
    chk("mid_idx0",  32'(bus.out_idx), 0);
    rst = 1'b1;
    expq.delete();
    exp_idx = 0; n_got = 0; stalled = 1'b0;
    send_pair(11, 1, 1'b0);
    drain(40);
    chk("mid_cnt", n_got, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
